// File: rtl/sync_fifo_pkg.sv
// Shared types for the synchronous FIFO read/write adapters.
package sync_fifo_pkg;

    localparam int BUF_DEPTH = 2;

    typedef logic [1:0] buf_cnt_t;

    // Encodings equal the number of words held, so the state doubles as a count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry output buffer that turns captured FIFO words into a valid/ready stream.
// Latency: a captured word is presented on m_data one edge later when the buffer is empty.
// Backpressure: m_data/m_valid hold while m_ready=0; the caller must not capture into a full buffer.
module stream_skid_buf2
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] capture_data,
    input  logic                  m_ready,
    output logic                  pop,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output buf_cnt_t              buf_count
);

    generate
        if (BUF_DEPTH != sync_fifo_pkg::BUF_DEPTH) begin : g_depth_check
            $error("stream_skid_buf2 supports BUF_DEPTH == 2 only");
        end
    endgenerate

    buf_state_e            state_q, state_n;
    logic [DATA_WIDTH-1:0] head_q, head_n;
    logic [DATA_WIDTH-1:0] tail_q, tail_n;
    logic                  m_valid_q;

    assign pop       = m_valid_q & m_ready;
    assign m_valid   = m_valid_q;
    assign m_data    = head_q;
    assign buf_count = buf_cnt_t'(state_q);

    always_comb begin
        state_n = state_q;
        head_n  = head_q;
        tail_n  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (capture) begin
                    state_n = BUF_ONE;
                    head_n  = capture_data;
                end
            end
            BUF_ONE: begin
                if (capture && !pop) begin
                    state_n = BUF_TWO;
                    tail_n  = capture_data;
                end else if (capture && pop) begin
                    head_n  = capture_data;
                end else if (pop) begin
                    state_n = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                // The issue logic never lets a word be in flight while both entries are full.
                if (pop) begin
                    state_n = BUF_ONE;
                    head_n  = tail_q;
                end
            end
            default: begin
                state_n = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BUF_EMPTY;
            head_q    <= '0;
            tail_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            head_q    <= head_n;
            tail_q    <= tail_n;
            m_valid_q <= (state_n != BUF_EMPTY);
        end
    end

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Drains the synchronous FIFO onto a valid/ready stream; optional counters under SYNC_FIFO_READER_STATS_EN.
// Latency: 2 cycles from fifo_empty falling to m_valid; 1 word/cycle sustained with m_ready high.
// Backpressure: reads are issued only while buffer space (counting the in-flight word) remains.
module sync_fifo_stream_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output buf_cnt_t              buf_count
`ifdef SYNC_FIFO_READER_STATS_EN
    ,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           words_out
`endif
);

    logic       inflight;
    logic       pop;
    logic [2:0] occupancy;

    assign occupancy = {1'b0, buf_count} + {2'b00, inflight};

    // The read launched now lands in the buffer two edges later; a same-cycle pop frees its slot.
    assign fifo_rd = reset_n & ~fifo_empty & ((occupancy < 3'd2) | pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd;
        end
    end

    stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid (
        .clk          (clk),
        .reset_n      (reset_n),
        .capture      (inflight),
        .capture_data (fifo_rdata),
        .m_ready      (m_ready),
        .pop          (pop),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .buf_count    (buf_count)
    );

`ifdef SYNC_FIFO_READER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            words_out    <= '0;
        end else begin
            if (m_valid && !m_ready && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (pop) begin
                words_out <= words_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader: FIFO model, per-cycle vector tables and an in-order scoreboard.
module tb_sync_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] buf_count;
`ifdef SYNC_FIFO_READER_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] words_out;
`endif

    always #5 clk = ~clk;

    sync_fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_rdata (fifo_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .buf_count  (buf_count)
`ifdef SYNC_FIFO_READER_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .words_out    (words_out)
`endif
    );

    // FIFO model: registered empty, read data one cycle after rd, pointers reset with reset_n.
    logic [7:0] mem [0:511];
    int wr_cnt = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_cnt);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= 0;
            fifo_rdata <= 8'hEE;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1;
        end else begin
            fifo_rdata <= 8'hEE;
        end
    end

    bit infl_tb = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) infl_tb <= 1'b0;
        else          infl_tb <= fifo_rd;
    end

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    int         n_pops = 0;
    int         n_stall_tb = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    typedef struct {
        logic       m_ready;
        logic       exp_rd;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_count;
    } vec_t;
    vec_t tab [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        int occ;
        if (reset_n) begin
            occ = int'(buf_count) + int'(infl_tb);
            check("occupancy_le_2", {31'b0, occ <= 2}, 1);
            if (prev_stall) begin
                check("stall_valid_hold", {31'b0, m_valid}, 1);
                check("stall_data_hold", {24'b0, m_data}, {24'b0, prev_data});
            end
            if (m_valid && m_ready) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_word: got %02h, no word expected", m_data);
                end else begin
                    check("order", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
                end
            end
            if (m_valid && !m_ready) n_stall_tb++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic to_stim();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        mem[wr_cnt] = d;
        wr_cnt++;
        exp_q.push_back(d);
    endtask

    task automatic clear_model();
        wr_cnt = 0;
        exp_q.delete();
        prev_stall = 1'b0;
        n_pops = 0;
        n_stall_tb = 0;
    endtask

    task automatic run_table(input int first, input int last, input string tag);
        for (int k = first; k <= last; k++) begin
            m_ready = tab[k].m_ready;
            to_neg();
            check($sformatf("%s_rd[%0d]", tag, k - first), {31'b0, fifo_rd}, {31'b0, tab[k].exp_rd});
            check($sformatf("%s_valid[%0d]", tag, k - first), {31'b0, m_valid}, {31'b0, tab[k].exp_valid});
            check($sformatf("%s_count[%0d]", tag, k - first), {30'b0, buf_count}, {30'b0, tab[k].exp_count});
            if (tab[k].exp_valid)
                check($sformatf("%s_data[%0d]", tag, k - first), {24'b0, m_data}, {24'b0, tab[k].exp_data});
            to_stim();
        end
    endtask

    initial begin
        int rd_pulses;
        int empty_low;
        int loaded;
        int cyc;
        int pops_before;
        bit found;

        // Streaming: 8 words, consumer always ready.
        for (int k = 0; k < 11; k++) begin
            tab[k].m_ready   = 1'b1;
            tab[k].exp_rd    = (k <= 7);
            tab[k].exp_valid = (k >= 2) && (k <= 9);
            tab[k].exp_data  = 8'(k - 1);
            tab[k].exp_count = ((k >= 2) && (k <= 9)) ? 2'd1 : 2'd0;
        end
        // Backpressure: 5 words, stalled for 5 cycles, then drained.
        tab[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tab[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tab[13] = '{1'b0, 1'b0, 1'b1, 8'h01, 2'd1};
        tab[14] = '{1'b0, 1'b0, 1'b1, 8'h01, 2'd2};
        tab[15] = '{1'b0, 1'b0, 1'b1, 8'h01, 2'd2};
        tab[16] = '{1'b1, 1'b1, 1'b1, 8'h01, 2'd2};
        tab[17] = '{1'b1, 1'b1, 1'b1, 8'h02, 2'd1};
        tab[18] = '{1'b1, 1'b1, 1'b1, 8'h03, 2'd1};
        tab[19] = '{1'b1, 1'b0, 1'b1, 8'h04, 2'd1};
        tab[20] = '{1'b1, 1'b0, 1'b1, 8'h05, 2'd1};
        tab[21] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

        reset_n = 1'b1;
        m_ready = 1'b1;
        #1;
        reset_n = 1'b0;
        clear_model();
        for (int i = 1; i <= 8; i++) load(8'(i));
        to_stim();
        to_neg();
        check("rd_in_reset", {31'b0, fifo_rd}, 0);
        to_stim();
        reset_n = 1'b1;
        check("reset_valid", {31'b0, m_valid}, 0);
        check("reset_count", {30'b0, buf_count}, 0);
        check("reset_data", {24'b0, m_data}, 0);
        run_table(0, 10, "stream");
        check("stream_drained", exp_q.size(), 0);

        reset_n = 1'b0;
        clear_model();
        to_stim();
        to_stim();
        for (int i = 1; i <= 5; i++) load(8'(i));
        reset_n = 1'b1;
        run_table(11, 21, "bp");
        check("bp_drained", exp_q.size(), 0);

        // Single word: empty is low for exactly the read cycle.
        m_ready = 1'b1;
        load(8'hA5);
        rd_pulses = 0;
        empty_low = 0;
        for (int i = 0; i < 6; i++) begin
            to_neg();
            if (fifo_rd) rd_pulses++;
            if (!fifo_empty) empty_low++;
            if (i == 2) begin
                check("last_valid", {31'b0, m_valid}, 1);
                check("last_data", {24'b0, m_data}, 32'hA5);
            end
            if (i == 3) check("last_no_dup", {31'b0, m_valid}, 0);
            to_stim();
        end
        check("last_rd_pulses", rd_pulses, 1);
        check("last_empty_low", empty_low, 1);

        // Random consumer, words trickled into the FIFO.
        loaded = 0;
        cyc = 0;
        pops_before = n_pops;
        while (!(loaded == 200 && exp_q.size() == 0) && cyc < 3000) begin
            if (loaded < 200 && $urandom_range(0, 1) == 1) begin
                load(8'($urandom_range(0, 255)));
                loaded++;
            end
            m_ready = ($urandom_range(0, 1) == 1);
            to_neg();
            to_stim();
            cyc++;
        end
        check("random_drained", exp_q.size(), 0);
        check("random_pops", n_pops - pops_before, 200);

        // Reset with a full buffer and a read being issued.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(8'h31 + i));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            to_neg();
            if (buf_count == 2'd2) found = 1'b1;
            else to_stim();
        end
        check("wait_buf_full", {31'b0, found}, 1);
        to_stim();
        m_ready = 1'b1;
        to_neg();
        check("midrst_count_pre", {30'b0, buf_count}, 2);
        check("midrst_rd_pre", {31'b0, fifo_rd}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, m_valid}, 0);
        check("midrst_count", {30'b0, buf_count}, 0);
        check("midrst_data", {24'b0, m_data}, 0);
        check("midrst_rd", {31'b0, fifo_rd}, 0);
        clear_model();
        to_stim();
        to_stim();
        load(8'h10);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            to_neg();
            to_stim();
        end
        check("midrst_pops", n_pops, 1);
        check("midrst_drained", exp_q.size(), 0);
`ifdef SYNC_FIFO_READER_STATS_EN
        check("stats_words_out", {16'b0, words_out}, n_pops);
        check("stats_stall", {16'b0, stall_cycles}, n_stall_tb);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
